// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
//   D-stage decode fields going into the hazard scoreboard, plus its stall,
//   forwarding-select and MD-busy results.
//   master: datapath side (drives D fields, consumes decisions)
//   slave : scoreboard side
interface hazard_scoreboard_if #(
  parameter int REG_W = 5,
  parameter int T_W   = 2
);
  logic             d_valid;
  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic [T_W-1:0]   d_tuse_rs;
  logic [T_W-1:0]   d_tuse_rt;
  logic [REG_W-1:0] d_a3;
  logic [T_W-1:0]   d_tnew;
  logic [1:0]       d_md;
  logic             stall;
  logic [1:0]       fwd_rs_d;
  logic [1:0]       fwd_rt_d;
  logic [1:0]       fwd_rs_e;
  logic [1:0]       fwd_rt_e;
  logic             fwd_rt_m;
  logic             md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew, d_md,
    input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_a3, d_tnew, d_md,
    output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard/forwarding controller for the 5-stage pipeline. Keeps its own
//   E/M/W shadow of in-flight destination writes and resolves stall and
//   forwarding selects with Tuse/Tnew arithmetic; also tracks the
//   multi-cycle mult/div unit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   sb    : slave side of hazard_scoreboard_if (D fields in, decisions out)
module hazard_scoreboard #(
  parameter int REG_W    = 5,
  parameter int T_W      = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input logic                clk,
  input logic                rst_n,
  hazard_scoreboard_if.slave sb
);
  localparam logic [T_W-1:0] TUSE_NONE = '1;

  typedef struct packed {
    logic [REG_W-1:0] a3;
    logic [T_W-1:0]   tnew;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [1:0]       md;
  } e_rec_t;

  typedef struct packed {
    logic [REG_W-1:0] a3;
    logic [T_W-1:0]   tnew;
    logic [REG_W-1:0] rt;
  } m_rec_t;

  e_rec_t           e_q;
  m_rec_t           m_q;
  logic [REG_W-1:0] w_a3;
  logic [CNT_W-1:0] md_cnt;

  logic       e_md_start, md_busy, stall;
  logic [2:0] rs_d, rt_d;  // {data-stall, fwd select}

  // Nearest producer wins even when not ready: that case yields select 0
  // and, if tnew exceeds Tuse, the stall. W is always ready.
  function automatic logic [2:0] d_resolve(input logic [REG_W-1:0] r,
                                           input logic [T_W-1:0]   tuse,
                                           input e_rec_t           e,
                                           input m_rec_t           m,
                                           input logic [REG_W-1:0] w);
    logic rd;
    rd = (r != '0) && (tuse != TUSE_NONE);
    if (rd && e.a3 == r) return {e.tnew > tuse, (e.tnew == '0) ? 2'd3 : 2'd0};
    if (rd && m.a3 == r) return {m.tnew > tuse, (m.tnew == '0) ? 2'd2 : 2'd0};
    if (rd && w == r)    return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [1:0] e_resolve(input logic [REG_W-1:0] r,
                                           input m_rec_t           m,
                                           input logic [REG_W-1:0] w);
    if (r == '0)   return 2'd0;
    if (m.a3 == r) return (m.tnew == '0) ? 2'd2 : 2'd0;
    if (w == r)    return 2'd1;
    return 2'd0;
  endfunction

  assign rs_d       = d_resolve(sb.d_rs, sb.d_tuse_rs, e_q, m_q, w_a3);
  assign rt_d       = d_resolve(sb.d_rt, sb.d_tuse_rt, e_q, m_q, w_a3);
  assign e_md_start = (e_q.md == 2'd1) || (e_q.md == 2'd2);
  assign md_busy    = (md_cnt != '0) || e_md_start;
  assign stall      = sb.d_valid &&
                      (rs_d[2] || rt_d[2] || ((sb.d_md != 2'd0) && md_busy));

  assign sb.stall    = stall;
  assign sb.md_busy  = md_busy;
  assign sb.fwd_rs_d = rs_d[1:0];
  assign sb.fwd_rt_d = rt_d[1:0];
  assign sb.fwd_rs_e = e_resolve(e_q.rs, m_q, w_a3);
  assign sb.fwd_rt_e = e_resolve(e_q.rt, m_q, w_a3);
  assign sb.fwd_rt_m = (m_q.rt != '0) && (w_a3 == m_q.rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= '0;
      m_q    <= '0;
      w_a3   <= '0;
      md_cnt <= '0;
    end else begin
      // A stalled or empty D slot becomes an all-zero bubble in E.
      if (sb.d_valid && !stall)
        e_q <= '{a3: sb.d_a3, tnew: sb.d_tnew, rs: sb.d_rs, rt: sb.d_rt, md: sb.d_md};
      else
        e_q <= '0;
      m_q.a3   <= e_q.a3;
      m_q.tnew <= (e_q.tnew == '0) ? '0 : e_q.tnew - T_W'(1);
      m_q.rt   <= e_q.rt;
      w_a3     <= m_q.a3;
      // Load takes priority even while D is stalled.
      if (e_q.md == 2'd1)      md_cnt <= CNT_W'(MULT_LAT);
      else if (e_q.md == 2'd2) md_cnt <= CNT_W'(DIV_LAT);
      else if (md_cnt != '0)   md_cnt <= md_cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;
  localparam int REG_W    = 5;
  localparam int T_W      = 2;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  hazard_scoreboard_if #(.REG_W(REG_W), .T_W(T_W)) bus();

  hazard_scoreboard #(
    .REG_W(REG_W), .T_W(T_W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sb(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want test done");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit v, input int rs, input int rt, input int tr,
                       input int tt, input int a3, input int tn, input int md);
    bus.d_valid   = v;
    bus.d_rs      = REG_W'(rs);
    bus.d_rt      = REG_W'(rt);
    bus.d_tuse_rs = T_W'(tr);
    bus.d_tuse_rt = T_W'(tt);
    bus.d_a3      = REG_W'(a3);
    bus.d_tnew    = T_W'(tn);
    bus.d_md      = 2'(md);
  endtask

  task automatic idle();
    drive(0, 0, 0, 3, 3, 0, 0, 0);
  endtask

  // Leaves time at posedge+1; checks happen 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input int n);
    idle();
    repeat (n) tick();
  endtask

  function automatic logic [10:0] outs();
    return {bus.stall, bus.md_busy, bus.fwd_rs_d, bus.fwd_rt_d,
            bus.fwd_rs_e, bus.fwd_rt_e, bus.fwd_rt_m};
  endfunction

  // ---------------- reference model (age-based in-flight list) ----------------
  typedef struct {
    bit v;
    int a3, tnew, rs, rt, md;
  } inst_t;

  inst_t hist[3];  // index = cycles since entering E (0=E, 1=M, 2=W)
  int    md_free;  // first cycle in which the MD unit is free
  int    cyc;

  function automatic void m_d_src(input int r, input int tuse, output int sel, output bit stl);
    int rem;
    sel = 0;
    stl = 0;
    if (r == 0 || tuse == 3) return;
    for (int k = 0; k < 3; k++) begin
      if (hist[k].v && hist[k].a3 == r) begin
        rem = hist[k].tnew - k;
        if (rem < 0) rem = 0;
        if (k == 2 || rem == 0) sel = 3 - k;
        stl = (k < 2) && (rem > tuse);
        return;
      end
    end
  endfunction

  function automatic int m_e_src(input int r);
    int rem;
    if (r == 0) return 0;
    for (int k = 1; k < 3; k++) begin
      if (hist[k].v && hist[k].a3 == r) begin
        if (k == 2) return 1;
        rem = hist[k].tnew - 1;
        return (rem <= 0) ? 2 : 0;
      end
    end
    return 0;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 3, 3, 0, 0, 3, 1, 1);
    #2;
    total++; if (outs() !== 11'b0) begin bad++; $display("FAIL reset_outs: got %h want 000", outs()); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    tick();
    #2;
    total++; if (outs() !== 11'b0) begin bad++; $display("FAIL reset_release_outs: got %h want 000", outs()); end
  endtask

  task automatic test_alu_fwd();
    flush(4);
    drive(1, 1, 2, 1, 1, 3, 1, 0);            // addu $3,$1,$2
    tick();
    drive(1, 3, 3, 1, 1, 4, 1, 0);            // addu $4,$3,$3
    #2;
    total++; if (bus.stall !== 1'b0)  begin bad++; $display("FAIL alu_nostall: got %0b want 0", bus.stall); end
    total++; if (bus.fwd_rs_d !== 2'd0) begin bad++; $display("FAIL alu_rs_d_notready: got %0d want 0", bus.fwd_rs_d); end
    tick();
    idle();
    #2;
    total++; if (bus.fwd_rs_e !== 2'd2) begin bad++; $display("FAIL alu_rs_e_m: got %0d want 2", bus.fwd_rs_e); end
    total++; if (bus.fwd_rt_e !== 2'd2) begin bad++; $display("FAIL alu_rt_e_m: got %0d want 2", bus.fwd_rt_e); end
    flush(4);
    drive(1, 1, 2, 1, 1, 3, 1, 0);            // addu $3
    tick();
    drive(1, 1, 2, 1, 1, 9, 1, 0);            // unrelated
    tick();
    drive(1, 3, 0, 1, 1, 4, 1, 0);            // addu $4,$3,$0
    tick();
    idle();
    #2;
    total++; if (bus.fwd_rs_e !== 2'd1) begin bad++; $display("FAIL alu_rs_e_w: got %0d want 1", bus.fwd_rs_e); end
    total++; if (bus.fwd_rt_e !== 2'd0) begin bad++; $display("FAIL alu_rt_e_zero: got %0d want 0", bus.fwd_rt_e); end
  endtask

  task automatic test_load_use();
    flush(4);
    drive(1, 0, 5, 1, 3, 5, 2, 0);            // lw $5,0($0)
    tick();
    drive(1, 5, 0, 1, 1, 6, 1, 0);            // addu $6,$5,$0
    #2;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall1: got %0b want 1", bus.stall); end
    tick();
    #2;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL lu_stall2: got %0b want 0", bus.stall); end
    tick();
    idle();
    #2;
    total++; if (bus.fwd_rs_e !== 2'd1) begin bad++; $display("FAIL lu_rs_e_w: got %0d want 1", bus.fwd_rs_e); end
  endtask

  task automatic test_branch();
    flush(4);
    drive(1, 0, 7, 1, 3, 7, 2, 0);            // lw $7
    tick();
    drive(1, 7, 0, 0, 0, 0, 0, 0);            // beq $7,$0
    #2;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL br_stall1: got %0b want 1", bus.stall); end
    tick();
    #2;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL br_stall2: got %0b want 1", bus.stall); end
    tick();
    #2;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL br_stall3: got %0b want 0", bus.stall); end
    total++; if (bus.fwd_rs_d !== 2'd1) begin bad++; $display("FAIL br_rs_d_w: got %0d want 1", bus.fwd_rs_d); end
    flush(4);
    drive(1, 0, 0, 3, 3, 31, 0, 0);           // jal
    tick();
    drive(1, 31, 0, 0, 3, 0, 0, 0);           // jr $31
    #2;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL jr_nostall: got %0b want 0", bus.stall); end
    total++; if (bus.fwd_rs_d !== 2'd3) begin bad++; $display("FAIL jr_rs_d_e: got %0d want 3", bus.fwd_rs_d); end
  endtask

  task automatic test_md_stall();
    flush(14);
    drive(1, 1, 2, 1, 1, 0, 0, 1);            // mult
    #2;
    total++; if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL md_idle: got %0b want 0", bus.md_busy); end
    tick();
    drive(1, 0, 0, 3, 3, 8, 1, 3);            // mflo
    for (int i = 0; i <= MULT_LAT; i++) begin
      #2;
      total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL md_stall[%0d]: got %0b want 1", i, bus.stall); end
      total++; if (bus.md_busy !== 1'b1) begin bad++; $display("FAIL md_busy[%0d]: got %0b want 1", i, bus.md_busy); end
      tick();
    end
    #2;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL md_stall_end: got %0b want 0", bus.stall); end
    total++; if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL md_busy_end: got %0b want 0", bus.md_busy); end
  endtask

  task automatic test_zero_unread();
    flush(14);
    drive(1, 1, 2, 1, 1, 0, 1, 0);            // addu $0,$1,$2
    tick();
    drive(1, 0, 0, 0, 0, 5, 1, 0);            // reads $0 twice
    #2;
    total++; if (outs() !== 11'b0) begin bad++; $display("FAIL zero_d_outs: got %h want 000", outs()); end
    tick();
    idle();
    #2;
    total++; if (outs() !== 11'b0) begin bad++; $display("FAIL zero_e_outs: got %h want 000", outs()); end
    flush(4);
    drive(1, 0, 9, 1, 3, 9, 2, 0);            // lw $9
    tick();
    drive(1, 0, 9, 1, 3, 0, 0, 0);            // rt=$9 but not read
    #2;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL unread_nostall: got %0b want 0", bus.stall); end
    total++; if (bus.fwd_rt_d !== 2'd0) begin bad++; $display("FAIL unread_rt_d: got %0d want 0", bus.fwd_rt_d); end
  endtask

  task automatic test_reset_mid();
    flush(14);
    drive(1, 1, 2, 1, 1, 0, 0, 2);            // div
    tick();
    drive(1, 0, 0, 3, 3, 8, 1, 3);            // mfhi
    #2;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL rm_stall_pre: got %0b want 1", bus.stall); end
    tick();
    #2;
    total++; if (bus.md_busy !== 1'b1) begin bad++; $display("FAIL rm_busy_pre: got %0b want 1", bus.md_busy); end
    rst_n = 1'b0;
    #1;
    total++; if (outs() !== 11'b0) begin bad++; $display("FAIL rm_async_outs: got %h want 000", outs()); end
    #1;
    rst_n = 1'b1;
    tick();
    #2;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rm_post_stall: got %0b want 0", bus.stall); end
    total++; if (bus.md_busy !== 1'b0) begin bad++; $display("FAIL rm_post_busy: got %0b want 0", bus.md_busy); end
    tick();
    idle();
    #2;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rm_proceed: got %0b want 0", bus.stall); end
  endtask

  task automatic test_random();
    int    r, sel_rs, sel_rt, e_rs, e_rt, m_rt;
    bit    st_rs, st_rt, busy, exp_stall;
    inst_t d;
    flush(14);
    for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0, 0, 0};
    md_free = 0;
    cyc = 0;
    for (int n = 0; n < 800; n++) begin
      d.v    = ($urandom_range(0, 4) != 0);
      d.rs   = $urandom_range(0, 3);
      d.rt   = $urandom_range(0, 3);
      d.a3   = $urandom_range(0, 3);
      d.tnew = $urandom_range(0, 2);
      r      = $urandom_range(0, 9);
      d.md   = (r < 7) ? 0 : r - 6;
      drive(d.v, d.rs, d.rt, $urandom_range(0, 3), $urandom_range(0, 3), d.a3, d.tnew, d.md);
      m_d_src(int'(bus.d_rs), int'(bus.d_tuse_rs), sel_rs, st_rs);
      m_d_src(int'(bus.d_rt), int'(bus.d_tuse_rt), sel_rt, st_rt);
      e_rs = m_e_src(hist[0].v ? hist[0].rs : 0);
      e_rt = m_e_src(hist[0].v ? hist[0].rt : 0);
      m_rt = (hist[1].v && hist[1].rt != 0 && hist[2].v && hist[2].a3 == hist[1].rt) ? 1 : 0;
      busy = (cyc < md_free);
      exp_stall = d.v && (st_rs || st_rt || (d.md != 0 && busy));
      #2;
      total++; if (bus.stall !== exp_stall) begin bad++; $display("FAIL rand_stall cyc=%0d: got %0b want %0b", cyc, bus.stall, exp_stall); end
      total++; if (bus.md_busy !== busy) begin bad++; $display("FAIL rand_busy cyc=%0d: got %0b want %0b", cyc, bus.md_busy, busy); end
      total++;
      if ({bus.fwd_rs_d, bus.fwd_rt_d, bus.fwd_rs_e, bus.fwd_rt_e, bus.fwd_rt_m} !==
          {2'(sel_rs), 2'(sel_rt), 2'(e_rs), 2'(e_rt), 1'(m_rt)}) begin
        bad++;
        $display("FAIL rand_fwd cyc=%0d: got rs_d=%0d rt_d=%0d rs_e=%0d rt_e=%0d rt_m=%0d want %0d %0d %0d %0d %0d",
                 cyc, bus.fwd_rs_d, bus.fwd_rt_d, bus.fwd_rs_e, bus.fwd_rt_e, bus.fwd_rt_m,
                 sel_rs, sel_rt, e_rs, e_rt, m_rt);
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (d.v && !exp_stall) begin
        hist[0] = d;
        if (d.md == 1) md_free = cyc + 2 + MULT_LAT;
        if (d.md == 2) md_free = cyc + 2 + DIV_LAT;
      end else begin
        hist[0] = '{0, 0, 0, 0, 0, 0};
      end
      cyc++;
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_branch();
    test_md_stall();
    test_zero_unread();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
